// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared width defaults, op encodings and FSM state encodings
// for the M-extension divider sequencer.
package div_ctrl_pkg;

    localparam int DIV_DW          = 32;
    localparam int DIV_TIMEOUT_DEF = 40;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_RESP = 2'd3
    } div_state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_sign_adj.sv
// div_sign_adj: conditional two's-complement negate, used both for operand
// magnitudes and for sign-correcting the core's results.
module div_sign_adj #(
    parameter int DW = 32
) (
    input  logic          i_neg,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_data
);

    // Modulo-2^DW negate: the most negative value maps to itself, which is its correct unsigned magnitude.
    assign o_data = i_neg ? -i_data : i_data;

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: sequences DIV/DIVU/REM/REMU between the issue stage and the unsigned
// divider core. Optional one-entry result cache enabled by defining DIV_OPCACHE_EN.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int DW          = DIV_DW,
    parameter int DIV_TIMEOUT = DIV_TIMEOUT_DEF
) (
    input  logic          cpu_clk,
    input  logic          cpu_rst,
    input  logic          flush,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [DW-1:0] req_src1,
    input  logic [DW-1:0] req_src2,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [DW-1:0] resp_data,
    output logic          resp_err,
    output logic          busy,
    output logic          div_start,
    output logic [DW-1:0] div_src_data1,
    output logic [DW-1:0] div_src_data2,
    input  logic          div_done,
    input  logic [DW-1:0] div_result,
    input  logic [DW-1:0] rem_result
);

    localparam int CW = $clog2(DIV_TIMEOUT + 1);

    div_state_e    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_is_rem, r_neg1, r_neg2;
    logic [DW-1:0] r_mag1, r_mag2, r_quo, r_rem;
    logic          r_div_start, r_resp_valid, r_resp_err;
    logic [DW-1:0] r_resp_data;

    logic          w_accept, w_signed, w_neg1, w_neg2, w_div0, w_ovf, w_timeout;
    logic [DW-1:0] w_abs1, w_abs2, w_spec_data, w_fix_quo, w_fix_rem;

    // NOTE: every variable gets a value on every path through always_comb, otherwise a latch is inferred.
    always_comb begin
        w_accept    = req_valid & req_ready;
        w_signed    = op_is_signed(req_op);
        w_neg1      = w_signed & req_src1[DW-1];
        w_neg2      = w_signed & req_src2[DW-1];
        w_div0      = (req_src2 == '0);
        w_ovf       = w_signed & (req_src1 == {1'b1, {(DW-1){1'b0}}}) & (req_src2 == '1);
        w_spec_data = '0;
        if (w_div0)
            w_spec_data = op_is_rem(req_op) ? req_src1 : '1;
        else if (w_ovf)
            w_spec_data = op_is_rem(req_op) ? '0 : req_src1;
    end

    assign w_timeout = (r_state == S_RUN) & ~flush & ~div_done & (r_cnt == CW'(DIV_TIMEOUT - 1));

    div_sign_adj #(.DW(DW)) u_abs1 (.i_neg(w_neg1),          .i_data(req_src1), .o_data(w_abs1));
    div_sign_adj #(.DW(DW)) u_abs2 (.i_neg(w_neg2),          .i_data(req_src2), .o_data(w_abs2));
    div_sign_adj #(.DW(DW)) u_fixq (.i_neg(r_neg1 ^ r_neg2), .i_data(r_quo),    .o_data(w_fix_quo));
    div_sign_adj #(.DW(DW)) u_fixr (.i_neg(r_neg1),          .i_data(r_rem),    .o_data(w_fix_rem));

`ifdef DIV_OPCACHE_EN
    logic          r_c_valid, r_c_signed, r_signed;
    logic [DW-1:0] r_c_src1, r_c_src2, r_c_quo, r_c_rem, r_src1, r_src2;
    logic          w_hit;

    assign w_hit = r_c_valid & (req_src1 == r_c_src1) & (req_src2 == r_c_src2)
                 & (w_signed == r_c_signed);

    // NOTE: the entry payload is reset along with its valid bit so no X can ever be forwarded to resp_data.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_c_valid  <= 1'b0;
            r_c_signed <= 1'b0;
            r_c_src1   <= '0;
            r_c_src2   <= '0;
            r_c_quo    <= '0;
            r_c_rem    <= '0;
            r_signed   <= 1'b0;
            r_src1     <= '0;
            r_src2     <= '0;
        end else begin
            if (w_accept) begin
                r_signed <= w_signed;
                r_src1   <= req_src1;
                r_src2   <= req_src2;
            end
            if (w_timeout) begin
                r_c_valid <= 1'b0;
            end else if (r_state == S_FIX && !flush) begin
                r_c_valid  <= 1'b1;
                r_c_signed <= r_signed;
                r_c_src1   <= r_src1;
                r_c_src2   <= r_src2;
                r_c_quo    <= w_fix_quo;
                r_c_rem    <= w_fix_rem;
            end
        end
    end
`endif

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_is_rem     <= 1'b0;
            r_neg1       <= 1'b0;
            r_neg2       <= 1'b0;
            r_mag1       <= '0;
            r_mag2       <= '0;
            r_quo        <= '0;
            r_rem        <= '0;
            r_div_start  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_data  <= '0;
        end else if (flush) begin
            r_state      <= S_IDLE;
            r_div_start  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_is_rem <= op_is_rem(req_op);
                        r_neg1   <= w_neg1;
                        r_neg2   <= w_neg2;
                        r_mag1   <= w_abs1;
                        r_mag2   <= w_abs2;
                        if (w_div0 | w_ovf) begin
                            r_resp_data  <= w_spec_data;
                            r_resp_valid <= 1'b1;
                            r_state      <= S_RESP;
`ifdef DIV_OPCACHE_EN
                        end else if (w_hit) begin
                            r_resp_data  <= op_is_rem(req_op) ? r_c_rem : r_c_quo;
                            r_resp_valid <= 1'b1;
                            r_state      <= S_RESP;
`endif
                        end else begin
                            r_cnt       <= '0;
                            r_div_start <= 1'b1;
                            r_state     <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (div_done) begin
                        r_quo       <= div_result;
                        r_rem       <= rem_result;
                        r_div_start <= 1'b0;
                        r_state     <= S_FIX;
                    end else if (w_timeout) begin
                        r_div_start  <= 1'b0;
                        r_resp_data  <= '0;
                        r_resp_err   <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_FIX: begin
                    r_resp_data  <= r_is_rem ? w_fix_rem : w_fix_quo;
                    r_resp_valid <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_resp_err   <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready     = (r_state == S_IDLE) & ~flush;
    assign busy          = (r_state != S_IDLE);
    assign div_start     = r_div_start;
    assign div_src_data1 = r_mag1;
    assign div_src_data2 = r_mag2;
    assign resp_valid    = r_resp_valid;
    assign resp_err      = r_resp_err;
    assign resp_data     = r_resp_data;

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed plus randomized checks of div_ctrl against a signed/unsigned
// arithmetic reference, using a behavioural core stub with programmable done delay.
module tb_div_ctrl;
    import div_ctrl_pkg::*;

    localparam int DW = 32;
    localparam int TO = 40;

    logic          cpu_clk = 1'b0;
    logic          cpu_rst = 1'b1;
    logic          flush = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'b00;
    logic [DW-1:0] req_src1 = '0, req_src2 = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [DW-1:0] resp_data;
    logic          resp_err;
    logic          busy;
    logic          div_start;
    logic [DW-1:0] div_src_data1, div_src_data2;
    logic          div_done;
    logic [DW-1:0] div_result, rem_result;

    int total = 0;
    int bad   = 0;

    // core stub: done after stub_delay extra RUN cycles (0 = combinational, <0 = never)
    int stub_delay = 0;
    int run_cnt    = 0;
    always @(posedge cpu_clk) run_cnt <= div_start ? run_cnt + 1 : 0;
    assign div_done   = div_start && (stub_delay >= 0) && (run_cnt >= stub_delay);
    assign div_result = (div_src_data2 != 0) ? div_src_data1 / div_src_data2 : '1;
    assign rem_result = (div_src_data2 != 0) ? div_src_data1 % div_src_data2 : div_src_data1;

    // model of the optional result cache
    logic          mc_valid = 1'b0;
    logic          mc_sgn;
    logic [DW-1:0] mc_a, mc_b;

    div_ctrl #(.DW(DW), .DIV_TIMEOUT(TO)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_src1(req_src1), .req_src2(req_src2),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_err(resp_err), .busy(busy), .div_start(div_start),
        .div_src_data1(div_src_data1), .div_src_data2(div_src_data2),
        .div_done(div_done), .div_result(div_result), .rem_result(rem_result)
    );

    always #5 cpu_clk = ~cpu_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_result(input logic [1:0] op, input logic [DW-1:0] a,
                                                 input logic [DW-1:0] b);
        int sa, sb;
        if (b == 0) return op[1] ? a : '1;
        if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? '0 : a;
            sa = a;
            sb = b;
            return op[1] ? DW'(sa % sb) : DW'(sa / sb);
        end
        return op[1] ? a % b : a / b;
    endfunction

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        int w = 0;
        while (!req_ready && w < 50) begin tick(); w++; end
        check("req_ready_before_issue", req_ready, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_src1  = a;
        req_src2  = b;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input int delay, input int hold);
        logic          special, hit, exp_err;
        logic [DW-1:0] exp_data, held;
        int            exp_lat, exp_starts, lat, starts;
        special = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        hit = 1'b0;
`ifdef DIV_OPCACHE_EN
        hit = mc_valid && a == mc_a && b == mc_b && mc_sgn == !op[0];
`endif
        if (special || hit) begin
            exp_lat = 1; exp_starts = 0; exp_err = 1'b0; exp_data = ref_result(op, a, b);
        end else if (delay < 0) begin
            exp_lat = TO + 1; exp_starts = TO; exp_err = 1'b1; exp_data = '0;
            mc_valid = 1'b0;
        end else begin
            exp_lat = delay + 3; exp_starts = delay + 1; exp_err = 1'b0;
            exp_data = ref_result(op, a, b);
            mc_valid = 1'b1; mc_a = a; mc_b = b; mc_sgn = !op[0];
        end
        stub_delay = delay;
        issue(op, a, b);
        lat = 1; starts = 0;
        while (!resp_valid && lat <= 200) begin
            if (div_start) starts++;
            tick();
            lat++;
        end
        check("resp_valid_seen", resp_valid, 1);
        check("latency", lat, exp_lat);
        check("div_start_cycles", starts, exp_starts);
        check("resp_data", resp_data, exp_data);
        check("resp_err", resp_err, exp_err);
        held = resp_data;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", resp_valid, 1);
            check("hold_data", resp_data, held);
            check("hold_req_ready", req_ready, 0);
            check("hold_busy", busy, 1);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("after_ack_valid", resp_valid, 0);
        check("after_ack_busy", busy, 0);
    endtask

    initial begin
        logic          seen;
        logic [1:0]    op;
        logic [DW-1:0] a, b;

        repeat (3) @(posedge cpu_clk);
        #1;
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_div_start", div_start, 0);
        check("rst_busy", busy, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_src1", div_src_data1, 0);
        cpu_rst = 1'b0;
        tick();
        check("idle_req_ready", req_ready, 1);

        // sign correction with a combinational core
        run_op(DIV_OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0);
        run_op(DIV_OP_REM, 32'hFFFF_FFF9, 32'd2, 0, 0);
        // divide by zero and signed overflow bypass the core
        run_op(DIV_OP_DIVU, 32'd100, 32'd0, 0, 0);
        run_op(DIV_OP_REMU, 32'd100, 32'd0, 0, 0);
        run_op(DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        run_op(DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        // back-pressure
        run_op(DIV_OP_REMU, 32'd10, 32'd3, 0, 5);

        // flush during RUN
        stub_delay = 33;
        issue(DIV_OP_DIVU, 32'd1000, 32'd7);
        repeat (9) tick();
        check("flush_in_run", div_start, 1);
        flush = 1'b1;
        #1;
        check("flush_req_ready", req_ready, 0);
        tick();
        flush = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_div_start", div_start, 0);
        check("flush_resp_valid", resp_valid, 0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (resp_valid) seen = 1'b1;
        end
        check("flush_no_resp", seen, 0);
        run_op(DIV_OP_DIVU, 32'd1000, 32'd7, 0, 0);

        // timeout
        run_op(DIV_OP_DIVU, 32'd5, 32'd3, -1, 0);

        // same operands: DIV then REM
        run_op(DIV_OP_DIV, 32'd50, 32'd7, 2, 0);
        run_op(DIV_OP_REM, 32'd50, 32'd7, 2, 0);

        // reset mid-operation
        stub_delay = 10;
        issue(DIV_OP_DIVU, 32'd77, 32'd5);
        repeat (3) tick();
        cpu_rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_div_start", div_start, 0);
        check("midrst_resp_valid", resp_valid, 0);
        check("midrst_resp_data", resp_data, 0);
        tick();
        cpu_rst = 1'b0;
        mc_valid = 1'b0;
        tick();

        // randomized traffic
        a = 32'd1; b = 32'd1;
        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                a = $urandom;
                case ($urandom_range(0, 7))
                    0:       b = '0;
                    1:       b = 32'($urandom_range(1, 9));
                    2:       b = -32'($urandom_range(1, 9));
                    3:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                    default: b = $urandom;
                endcase
            end
            run_op(op, a, b, $urandom_range(0, 5), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
